// File: rtl/muxn_pipe.sv
`default_nettype none
// ============================================================================
// Module      : muxn_pipe
// Description : N-way, WIDTH-bit channel selector with a registered output
//               stage and a two-entry skid buffer. Valid/ready handshake on
//               both sides, in-order delivery at one beat per cycle, flush.
// Revision    : 1.0 - initial release
// ============================================================================
module muxn_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   i_data,
    input  logic [SELW-1:0]      i_sel,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_flush,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_selerr
);

    // Occupancy of the two-entry pipe: main register only, or main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_data;
    logic               r_selerr;
    logic [WIDTH-1:0]   r_skid_data;
    logic               r_skid_selerr;

    logic [WIDTH-1:0]   w_beat_data;
    logic               w_beat_selerr;
    logic               w_skid_valid;
    logic               w_accept;
    logic               w_pop;
    logic               w_ld_main_in;
    logic               w_ld_main_skid;
    logic               w_ld_skid;

    // ------------------------------------------------------------------------
    // Beat formation: pick the selected channel; an out-of-range select gives
    // an all-zero beat tagged with selerr.
    // ------------------------------------------------------------------------
    if (N == 1) begin : g_single
        logic w_unused_sel;
        assign w_unused_sel = ^i_sel;

        // Single channel: the select is meaningless and never an error.
        always_comb begin
            w_beat_data   = i_data[WIDTH-1:0];
            w_beat_selerr = 1'b0;
        end
    end else begin : g_multi
        localparam logic [SELW:0] c_n = (SELW + 1)'(N);

        // Channel mux with range check for non-power-of-two channel counts.
        always_comb begin
            w_beat_data   = '0;
            w_beat_selerr = 1'b0;
            if ({1'b0, i_sel} >= c_n) begin
                w_beat_selerr = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (i_sel == SELW'(k)) begin
                        w_beat_data = i_data[k*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    assign o_valid      = (r_state != ST_EMPTY);
    assign w_skid_valid = (r_state == ST_FULL);
    assign o_ready      = !w_skid_valid && !reset;
    assign w_accept     = i_valid && o_ready;
    assign w_pop        = o_valid && i_ready;
    assign o_data       = r_data;
    assign o_selerr     = r_selerr;

    // Next occupancy and register load selects; flush drops everything.
    always_comb begin
        w_state_next   = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_ld_main_in = 1'b1;
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_ld_main_in = 1'b1;
                end else if (w_accept) begin
                    w_ld_skid    = 1'b1;
                    w_state_next = ST_FULL;
                end else if (w_pop) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_ld_main_skid = 1'b1;
                    w_state_next   = ST_ONE;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
        if (i_flush) begin
            w_state_next   = ST_EMPTY;
            w_ld_main_in   = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid      = 1'b0;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Main and skid datapath registers; main only changes when empty or popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data        <= '0;
            r_selerr      <= 1'b0;
            r_skid_data   <= '0;
            r_skid_selerr <= 1'b0;
        end else begin
            if (w_ld_main_in) begin
                r_data   <= w_beat_data;
                r_selerr <= w_beat_selerr;
            end else if (w_ld_main_skid) begin
                r_data   <= r_skid_data;
                r_selerr <= r_skid_selerr;
            end
            if (w_ld_skid) begin
                r_skid_data   <= w_beat_data;
                r_skid_selerr <= w_beat_selerr;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered output stage and a two-entry skid buffer.
- Uses a valid/ready handshake on both sides, with flush support.
- Successor to the combinational 2:1 datapath mux. Used where pipeline stages need selection plus stall/flush handling: PC-source, forwarding and writeback result selection.
- Sits between producer and consumer stages. Full throughput of 1 beat per cycle, in-order delivery.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (N >= 1).
- SELW, (N>1 ? $clog2(N) : 1), select width. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- i_data  input  N*WIDTH  packed channels; channel k = i_data[k*WIDTH +: WIDTH].
- i_sel  input  SELW  channel select for the offered beat.
- i_valid  input  1  upstream beat offered.
- o_ready  output  1  block can accept a beat this cycle.
- i_flush  input  1  discard all held and incoming beats.
- o_data  output  WIDTH  selected data of head beat.
- o_valid  output  1  head beat valid.
- i_ready  input  1  downstream accepts head beat.
- o_selerr  output  1  head beat was captured with out-of-range select.

Behaviour:
- Storage: main register (o_data, o_selerr, o_valid) and skid register (data, selerr, valid). All registered; no combinational path from i_* to o_data/o_valid.
- Accept = i_valid && o_ready. Pop = o_valid && i_ready.
- o_ready = !skid_valid && !reset. o_ready is 0 while reset is asserted.
- Capture value: i_data channel i_sel.
  - If i_sel >= N (only possible when N is not a power of two), data = 0 and selerr = 1.
  - When N=1, i_sel is ignored and selerr = 0.
- Latency: beat accepted at edge t is visible on o_data/o_valid after edge t (1 cycle).
- States:
  - EMPTY (!o_valid).
  - ONE (o_valid, !skid_valid).
  - FULL (o_valid, skid_valid).
- Transitions per edge, i_flush = 0:
  - EMPTY: accept -> ONE (main <= beat); else stay.
  - ONE, accept & pop: main <= beat, stay ONE.
  - ONE, accept & !pop: skid <= beat -> FULL.
  - ONE, !accept & pop: -> EMPTY.
  - ONE, neither: hold.
  - FULL (no accept possible), pop: main <= skid, skid_valid <= 0 -> ONE.
  - FULL, !pop: hold.
- Main register contents, including o_data, change only when main is empty or popped (stable while o_valid && !i_ready).
- Flush:
  - i_flush=1 at an edge: o_valid <= 0, skid_valid <= 0; next state EMPTY.
  - A beat accepted in the same cycle is dropped.
  - A pop in the same cycle still counts as consumed downstream.
  - o_data / o_selerr keep their last value after flush (don't-care while !o_valid).
- Reset, asynchronous:
  - Immediately: o_valid=0, o_data=0, o_selerr=0, skid_valid=0, skid data=0, o_ready=0.
  - After deassertion, o_ready=1 combinationally.
  - Reset mid-transfer loses all held beats.
- Ordering: strict FIFO over the 2 entries; no reordering, no duplication, no loss except by flush/reset.
- Widths: no arithmetic; out-of-range select yields all-zero WIDTH.

Test Plan:
- Reset, N=4, WIDTH=32: assert reset mid-cycle -> o_valid, o_data, o_selerr, o_ready all 0 immediately. After release, o_ready=1.
- Streaming: channels {0x11,0x22,0x33,0x44}, i_sel 0,1,2,3 on consecutive cycles, i_valid=1, i_ready=1 -> o_data 0x11,0x22,0x33,0x44 one cycle after each accept; o_ready stays 1.
- Backpressure/skid: i_ready=0, offer sel=2 (0x33) then sel=3 (0x44) -> o_data=0x33 held, o_ready=0 after second accept. Raise i_ready -> 0x33, then 0x44 delivered in order; o_ready returns 1 one cycle after first pop.
- Out-of-range: N=3, i_sel=3 with i_data nonzero -> beat delivered with o_data=0, o_selerr=1. Next beat with sel=1 -> o_selerr=0.
- Flush: FULL state plus i_flush=1 and i_valid=1 same cycle -> next cycle o_valid=0, o_ready=1. The flushed and incoming beats never appear.
- Simultaneous accept+pop in ONE: i_ready=1, new beat sel=0 every cycle for 10 cycles -> 10 beats out, never FULL, no bubble.
